// File: rtl/stream_checker.sv
// Token-stream consumer: requests tokens, checks each against (start_value+k)*mult+offset.
// Optional idle timeout enabled by defining STREAM_CHECKER_TIMEOUT_EN.
module stream_checker #(
  parameter int data_width     = 32,
  parameter int consumer_id    = 0,
  parameter int mult           = 3,
  parameter int offset         = 2,
  parameter int start_value    = 0,
  parameter int max_data_size  = 5000,
  parameter int timeout_cycles = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  output logic                  req,
  input  logic                  ack,
  input  logic [data_width-1:0] din,
  output logic [31:0]           count,
  output logic [31:0]           err_count,
  output logic [31:0]           first_err_idx,
  output logic [data_width-1:0] first_err_data,
  output logic                  done,
  output logic                  pass
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [data_width-1:0] EXP_INIT =
    data_width'(longint'(start_value) * longint'(mult) + longint'(offset));
  localparam logic [data_width-1:0] EXP_STEP = data_width'(mult);
  localparam logic [31:0]           MAX_CNT  = 32'(max_data_size);
  localparam logic [31:0]           NO_ERR   = 32'hFFFF_FFFF;

  logic [1:0]            state_q, state_d;
  logic                  req_q, req_d;
  logic                  ack_dly_q, ack_dly_d;
  logic [31:0]           count_q, count_d;
  logic [31:0]           err_q, err_d;
  logic [31:0]           fei_q, fei_d;
  logic [data_width-1:0] fed_q, fed_d;
  logic [data_width-1:0] exp_q, exp_d;
  logic                  accept;
  logic                  timeout_flag;
  logic                  unused_cfg;

  // Only the rising edge of ack is a token, so a long ack is counted once.
  assign accept = (state_q == S_RUN) && ack && !ack_dly_q;

`ifdef STREAM_CHECKER_TIMEOUT_EN
  localparam logic [31:0] TMO_CNT = 32'(timeout_cycles);

  logic [31:0] idle_q, idle_d;
  logic        timeout_q, timeout_d;

  assign timeout_flag = timeout_q;
  assign unused_cfg   = ^{32'(consumer_id)};
`else
  assign timeout_flag = 1'b0;
  assign unused_cfg   = ^{32'(consumer_id), 32'(timeout_cycles)};
`endif

  always_comb begin
    state_d   = state_q;
    req_d     = req_q;
    ack_dly_d = ack;
    count_d   = count_q;
    err_d     = err_q;
    fei_d     = fei_q;
    fed_d     = fed_q;
    exp_d     = exp_q;
`ifdef STREAM_CHECKER_TIMEOUT_EN
    idle_d    = idle_q;
    timeout_d = timeout_q;
`endif
    case (state_q)
      S_IDLE: begin
        req_d = 1'b0;
        if (enable) state_d = S_RUN;
      end
      S_RUN: begin
        req_d = enable;
        if (accept) begin
          count_d = count_q + 32'd1;
          exp_d   = exp_q + EXP_STEP;
          if (din != exp_q) begin
            err_d = err_q + 32'd1;
            if (err_q == 32'd0) begin
              fei_d = count_q;
              fed_d = din;
            end
          end
          if (count_d == MAX_CNT) begin
            state_d = S_DONE;
            req_d   = 1'b0;
          end
        end
`ifdef STREAM_CHECKER_TIMEOUT_EN
        // Stall time with enable low is not charged against the upstream.
        if (accept) begin
          idle_d = 32'd0;
        end else if (enable) begin
          idle_d = idle_q + 32'd1;
          if (idle_d == TMO_CNT) begin
            state_d   = S_DONE;
            req_d     = 1'b0;
            timeout_d = 1'b1;
          end
        end
`endif
      end
      S_DONE: begin
        req_d = 1'b0;
      end
      default: begin
        state_d = S_IDLE;
        req_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      req_q     <= 1'b0;
      ack_dly_q <= 1'b0;
      count_q   <= 32'd0;
      err_q     <= 32'd0;
      fei_q     <= NO_ERR;
      fed_q     <= '0;
      exp_q     <= EXP_INIT;
`ifdef STREAM_CHECKER_TIMEOUT_EN
      idle_q    <= 32'd0;
      timeout_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      req_q     <= req_d;
      ack_dly_q <= ack_dly_d;
      count_q   <= count_d;
      err_q     <= err_d;
      fei_q     <= fei_d;
      fed_q     <= fed_d;
      exp_q     <= exp_d;
`ifdef STREAM_CHECKER_TIMEOUT_EN
      idle_q    <= idle_d;
      timeout_q <= timeout_d;
`endif
    end
  end

  assign req            = req_q;
  assign count          = count_q;
  assign err_count      = err_q;
  assign first_err_idx  = fei_q;
  assign first_err_data = fed_q;
  assign done           = (state_q == S_DONE);
  assign pass           = done && (err_q == 32'd0) && !timeout_flag;

endmodule
